// File: rtl/hdmi_rx_pkg.sv
// Shared definitions for the HDMI receive bring-up sequencer:
// state encoding, default counts and timer sizing.
package hdmi_rx_pkg;

   typedef enum logic [2:0] {
      ST_RST_PLL   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_RST_PHY   = 3'd2,
      ST_ALIGN     = 3'd3,
      ST_READY     = 3'd4,
      ST_FAIL      = 3'd5
   } rx_state_e;

   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_PLL_RST_CYCLES = 16;
   localparam int DEF_STABLE_CYCLES  = 1024;
   localparam int DEF_PHY_RST_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT   = 65535;
   localparam int DEF_ALIGN_TIMEOUT  = 65535;
   localparam int DEF_RETRY_MAX      = 3;

   // Width of the shared timer: clog2 of the largest count it must reach.
   function automatic int timer_width(input int a, input int b, input int c,
                                      input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/hdmi_rx_bringup_ctrl_sync.sv
// Multi-flop synchroniser for a bus of independent asynchronous status bits.
// Every stage resets to 0 so status reads as deasserted until proven otherwise.
module sync_bus_2ff #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/hdmi_rx_bringup_ctrl.sv
// HDMI RX front-end bring-up: PLL reset, lock/clock qualification, PHY reset,
// channel alignment, with bounded retries before latching failure.
//
//   state      | meaning
//   RST_PLL    | hold PLL and PHY in reset
//   WAIT_LOCK  | PLL released, wait for stable lock + TMDS clock
//   RST_PHY    | hold PHY reset while lock stays good
//   ALIGN      | PHY released, wait for all three channels aligned
//   READY      | link up
//   FAIL       | retries exhausted, wait for restart
module hdmi_rx_bringup_ctrl
   import hdmi_rx_pkg::*;
#(
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int PHY_RST_CYCLES = DEF_PHY_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int ALIGN_TIMEOUT  = DEF_ALIGN_TIMEOUT,
   parameter int RETRY_MAX      = DEF_RETRY_MAX
) (
   input  logic       outclk,
   input  logic       areset,
   input  logic       pll_locked_a,
   input  logic       tmds_clk_det_a,
   input  logic [2:0] align_done_a,
   input  logic       restart,
   output logic       pll_rst,
   output logic       phy_rst,
   output logic       align_start,
   output logic       rx_ready,
   output logic       fail,
   output logic [1:0] retry_cnt,
   output logic [2:0] state_o
);

   localparam int TW = timer_width(PLL_RST_CYCLES, STABLE_CYCLES, PHY_RST_CYCLES,
                                   LOCK_TIMEOUT, ALIGN_TIMEOUT);
   localparam logic [TW-1:0] T_PLL    = TW'(PLL_RST_CYCLES - 1);
   localparam logic [TW-1:0] T_STABLE = TW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] T_PHY    = TW'(PHY_RST_CYCLES - 1);
   localparam logic [TW-1:0] T_LOCK   = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] T_ALIGN  = TW'(ALIGN_TIMEOUT - 1);
   localparam logic [1:0]    R_LAST   = 2'(RETRY_MAX - 1);

   logic [4:0]    sync_q;
   logic          lk, cd, link;
   logic [2:0]    al;
   rx_state_e     state, state_n;
   logic [TW-1:0] timer, stab;
   logic [1:0]    retry_n;
   logic          timeout;

   sync_bus_2ff #(.WIDTH(5), .STAGES(SYNC_STAGES)) u_sync (
      .clk (outclk),
      .rst (areset),
      .d   ({align_done_a, tmds_clk_det_a, pll_locked_a}),
      .q   (sync_q)
   );

   assign lk   = sync_q[0];
   assign cd   = sync_q[1];
   assign al   = sync_q[4:2];
   assign link = lk & cd;

   always_comb begin
      state_n = state;
      retry_n = retry_cnt;
      timeout = 1'b0;
      if (restart) begin
         state_n = ST_RST_PLL;
         if (state == ST_FAIL) retry_n = '0;
      end else begin
         case (state)
            ST_RST_PLL:   if (timer == T_PLL) state_n = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
               if (link && stab == T_STABLE) state_n = ST_RST_PHY;
               else if (timer == T_LOCK)     timeout = 1'b1;
            end
            ST_RST_PHY: begin
               if (!link)               state_n = ST_RST_PLL;
               else if (timer == T_PHY) state_n = ST_ALIGN;
            end
            ST_ALIGN: begin
               if (!link)                 state_n = ST_RST_PLL;
               else if (al == 3'b111)     state_n = ST_READY;
               else if (timer == T_ALIGN) timeout = 1'b1;
            end
            ST_READY: if (!(link && (&al))) state_n = ST_RST_PLL;
            ST_FAIL:  state_n = ST_FAIL;
            default:  state_n = ST_RST_PLL;
         endcase
      end
      if (timeout) begin
         if (retry_cnt == R_LAST) begin
            state_n = ST_FAIL;
         end else begin
            retry_n = retry_cnt + 2'd1;
            state_n = ST_RST_PLL;
         end
      end
      if (state_n == ST_READY && state != ST_READY) retry_n = '0;
   end

   // Outputs are registered from the next state so they line up with state_o.
   always_ff @(posedge outclk) begin
      if (areset) begin
         state       <= ST_RST_PLL;
         timer       <= '0;
         stab        <= '0;
         retry_cnt   <= '0;
         pll_rst     <= 1'b1;
         phy_rst     <= 1'b1;
         align_start <= 1'b0;
         rx_ready    <= 1'b0;
         fail        <= 1'b0;
      end else begin
         state     <= state_n;
         retry_cnt <= retry_n;
         if (state_n != state || restart) timer <= '0;
         else if (timer != '1)            timer <= timer + TW'(1);
         if (state != ST_WAIT_LOCK || !link) stab <= '0;
         else if (stab != '1)                stab <= stab + TW'(1);
         pll_rst     <= (state_n == ST_RST_PLL) || (state_n == ST_FAIL);
         phy_rst     <= (state_n == ST_RST_PLL) || (state_n == ST_WAIT_LOCK) ||
                        (state_n == ST_RST_PHY) || (state_n == ST_FAIL);
         align_start <= (state_n == ST_ALIGN) && (state != ST_ALIGN);
         rx_ready    <= (state_n == ST_READY);
         fail        <= (state_n == ST_FAIL);
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_hdmi_rx_bringup_ctrl.sv
// Bench for hdmi_rx_bringup_ctrl: directed bring-up scenarios checked every
// cycle against a behavioural model, plus hand-computed checkpoints.
module tb_hdmi_rx_bringup_ctrl;

   localparam int P_SYNC   = 2;
   localparam int P_PLL    = 4;
   localparam int P_STABLE = 8;
   localparam int P_PHY    = 4;
   localparam int P_LOCK   = 64;
   localparam int P_ALIGN  = 32;
   localparam int P_RETRY  = 2;

   logic       outclk = 1'b0;
   logic       areset = 1'b1;
   logic       pll_locked_a = 1'b0;
   logic       tmds_clk_det_a = 1'b0;
   logic [2:0] align_done_a = 3'b000;
   logic       restart = 1'b0;
   logic       pll_rst, phy_rst, align_start, rx_ready, fail;
   logic [1:0] retry_cnt;
   logic [2:0] state_o;

   int n_cmp = 0;
   int n_bad = 0;
   int ncyc = 0;
   bit cmp_en = 0;

   // model: state number (spec encoding), cycles in state, lock run length, retries
   int m_st = 0, m_t = 0, m_run = 0, m_retry = 0;
   logic [4:0] m_hist [$];

   hdmi_rx_bringup_ctrl #(
      .SYNC_STAGES(P_SYNC), .PLL_RST_CYCLES(P_PLL), .STABLE_CYCLES(P_STABLE),
      .PHY_RST_CYCLES(P_PHY), .LOCK_TIMEOUT(P_LOCK), .ALIGN_TIMEOUT(P_ALIGN),
      .RETRY_MAX(P_RETRY)
   ) dut (
      .outclk(outclk), .areset(areset), .pll_locked_a(pll_locked_a),
      .tmds_clk_det_a(tmds_clk_det_a), .align_done_a(align_done_a),
      .restart(restart), .pll_rst(pll_rst), .phy_rst(phy_rst),
      .align_start(align_start), .rx_ready(rx_ready), .fail(fail),
      .retry_cnt(retry_cnt), .state_o(state_o)
   );

   always #5 outclk = ~outclk;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   task automatic model_step();
      logic [4:0] sv;
      logic       lnk;
      logic [2:0] al;
      int         nxt;
      bit         to;
      if (areset) begin
         m_st = 0; m_t = 0; m_run = 0; m_retry = 0;
         m_hist.delete();
         repeat (P_SYNC) m_hist.push_back(5'b0);
         return;
      end
      sv = m_hist.pop_front();
      m_hist.push_back({align_done_a, tmds_clk_det_a, pll_locked_a});
      lnk = sv[0] & sv[1];
      al  = sv[4:2];
      nxt = m_st;
      to  = 0;
      if (restart) begin
         nxt = 0;
         if (m_st == 5) m_retry = 0;
      end else begin
         case (m_st)
            0: if (m_t == P_PLL - 1) nxt = 1;
            1: begin
               m_run = lnk ? m_run + 1 : 0;
               if (m_run == P_STABLE) nxt = 2;
               else if (m_t == P_LOCK - 1) to = 1;
            end
            2: if (!lnk) nxt = 0; else if (m_t == P_PHY - 1) nxt = 3;
            3: begin
               if (!lnk) nxt = 0;
               else if (al == 3'b111) nxt = 4;
               else if (m_t == P_ALIGN - 1) to = 1;
            end
            4: if (!(lnk && al == 3'b111)) nxt = 0;
            default: ;
         endcase
      end
      if (to) begin
         if (m_retry == P_RETRY - 1) nxt = 5;
         else begin m_retry++; nxt = 0; end
      end
      if (nxt == 4 && m_st != 4) m_retry = 0;
      if (nxt != m_st || restart) begin m_t = 0; m_run = 0; end
      else m_t++;
      m_st = nxt;
   endtask

   always @(posedge outclk) model_step();

   always @(negedge outclk) begin
      if (cmp_en) begin
         check("pll_rst",     pll_rst,     (m_st == 0 || m_st == 5));
         check("phy_rst",     phy_rst,     (m_st <= 2 || m_st == 5));
         check("align_start", align_start, (m_st == 3 && m_t == 0));
         check("rx_ready",    rx_ready,    (m_st == 4));
         check("fail",        fail,        (m_st == 5));
         check("retry_cnt",   retry_cnt,   m_retry);
         check("state_o",     state_o,     m_st);
      end
   end

   task automatic step();
      @(negedge outclk);
      ncyc++;
   endtask

   task automatic go_to(input int c);
      while (ncyc < c) step();
   endtask

   task automatic wait_align_start(input string name);
      bit found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         if (align_start === 1'b1) found = 1;
      end
      check(name, found, 1);
   endtask

   initial begin
      int k;
      repeat (3) @(negedge outclk);
      cmp_en = 1;
      areset = 0;
      ncyc   = 0;

      // clean bring-up
      go_to(3);  check("lit_pll_rst_c3", pll_rst, 1);
      go_to(4);  check("lit_pll_rst_c4", pll_rst, 0); check("lit_state_c4", state_o, 1);
      go_to(10); pll_locked_a = 1; tmds_clk_det_a = 1;
      go_to(19); check("lit_state_c19", state_o, 1);
      go_to(20); check("lit_state_c20", state_o, 2); check("lit_phy_rst_c20", phy_rst, 1);
      go_to(24); check("lit_align_start_c24", align_start, 1); check("lit_phy_rst_c24", phy_rst, 0);
      go_to(25); check("lit_align_start_c25", align_start, 0);
      go_to(26); align_done_a = 3'b111;
      go_to(28); check("lit_rx_ready_c28", rx_ready, 0);
      go_to(29); check("lit_rx_ready_c29", rx_ready, 1); check("lit_state_c29", state_o, 4);
      check("lit_retry_c29", retry_cnt, 0); check("lit_model_st_c29", m_st, 4);

      // loss of TMDS clock in READY
      go_to(40); tmds_clk_det_a = 0;
      go_to(42); check("lit_rx_ready_c42", rx_ready, 1);
      go_to(43); check("lit_rx_ready_c43", rx_ready, 0); check("lit_state_c43", state_o, 0);
      check("lit_retry_c43", retry_cnt, 0);
      go_to(45); tmds_clk_det_a = 1;

      // one-cycle lock glitch at stability count 5
      go_to(50); pll_locked_a = 0;
      go_to(51); pll_locked_a = 1;
      go_to(55); align_done_a = 3'b011;
      go_to(60); check("lit_state_c60", state_o, 1);
      go_to(61); check("lit_state_c61", state_o, 2);

      // align stuck at 011: two timeouts then FAIL
      go_to(65); check("lit_align_start_c65", align_start, 1);
      go_to(96); check("lit_state_c96", state_o, 3);
      go_to(97); check("lit_state_c97", state_o, 0); check("lit_retry_c97", retry_cnt, 1);
      go_to(144); check("lit_state_c144", state_o, 3);
      go_to(145); check("lit_state_c145", state_o, 5); check("lit_fail_c145", fail, 1);
      check("lit_pll_rst_c145", pll_rst, 1); check("lit_retry_c145", retry_cnt, 1);
      check("lit_model_retry_c145", m_retry, 1);
      go_to(150); check("lit_state_c150", state_o, 5);
      restart = 1;
      go_to(151); restart = 0;
      check("lit_state_c151", state_o, 0); check("lit_fail_c151", fail, 0);
      check("lit_retry_c151", retry_cnt, 0);

      // areset while align_start is high
      wait_align_start("wait_align_start_rst");
      areset = 1;
      step();
      check("lit_rst_pll_rst", pll_rst, 1);       check("lit_rst_phy_rst", phy_rst, 1);
      check("lit_rst_align_start", align_start, 0); check("lit_rst_rx_ready", rx_ready, 0);
      check("lit_rst_fail", fail, 0);             check("lit_rst_retry", retry_cnt, 0);
      check("lit_rst_state", state_o, 0);
      areset = 0;
      ncyc   = 0;

      // success arrives on the last ALIGN timeout cycle
      wait_align_start("wait_align_start_edge");
      k = ncyc;
      go_to(k + 29); align_done_a = 3'b111;
      go_to(k + 31); check("lit_edge_state_pre", state_o, 3);
      go_to(k + 32); check("lit_edge_state", state_o, 4);
      check("lit_edge_rx_ready", rx_ready, 1); check("lit_edge_retry", retry_cnt, 0);

      // lock loss in READY
      go_to(k + 35); pll_locked_a = 0;
      go_to(k + 40); check("lit_lockloss_state", state_o, 0);
      check("lit_lockloss_rx_ready", rx_ready, 0);
      go_to(k + 43);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (compared %0d, mismatched %0d)",
               n_cmp, n_bad);
      $fatal(1);
   end

endmodule
